// File: rtl/fp_matvec_pkg.sv
// fp_matvec_pkg: shared constants, FSM encoding and helpers
// for the sequential FP matrix-vector engine.
package fp_matvec_pkg;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/fp_matvec_seq_if.sv
// fp_matvec_seq_if: start/busy/done handshake plus operand
// and result buses of the matrix-vector engine.
interface fp_matvec_seq_if #(
   parameter int BW = 32,
   parameter int M  = 12,
   parameter int N  = 10
);
   logic              start;
   logic              use_bias;
   logic [BW*M*N-1:0] A;
   logic [BW*N-1:0]   B;
   logic [BW*M-1:0]   D;
   logic [BW*M-1:0]   C;
   logic              busy;
   logic              done;
   logic              exc;

   modport master (
      output start, use_bias, A, B, D,
      input  C, busy, done, exc
   );

   modport slave (
      input  start, use_bias, A, B, D,
      output C, busy, done, exc
   );
endinterface

// File: rtl/fp_matvec_seq_lane.sv
// fp_mac_lane: one single-precision multiply-accumulate lane,
// with its FP multiplier and adder cores (denormals flush to zero).
module multiplier_fp (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] result_o,
   output logic        exception_o,
   output logic        overflow_o,
   output logic        underflow_o
);
   logic              sgn, zero, nan, g, st, inc;
   logic [7:0]        ea, eb;
   logic [47:0]       p;
   logic [22:0]       man;
   logic [23:0]       rnd;
   logic signed [9:0] e;

   // Mantissa product, normalise by one, round to nearest even.
   always_comb begin
      sgn = a_i[31] ^ b_i[31];
      ea = a_i[30:23];
      eb = b_i[30:23];
      exception_o = (ea == 8'hFF) || (eb == 8'hFF);
      zero = (ea == 8'h00) || (eb == 8'h00);
      nan = ((ea == 8'hFF) && (a_i[22:0] != 23'd0)) ||
            ((eb == 8'hFF) && (b_i[22:0] != 23'd0)) ||
            (exception_o && zero);
      p = {1'b1, a_i[22:0]} * {1'b1, b_i[22:0]};
      e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
      if (p[47]) begin
         man = p[46:24];
         g   = p[23];
         st  = |p[22:0];
         e   = e + 10'sd1;
      end else begin
         man = p[45:23];
         g   = p[22];
         st  = |p[21:0];
      end
      inc = g & (st | man[0]);
      rnd = {1'b0, man} + {23'd0, inc};
      e = e + $signed({9'd0, rnd[23]});
      overflow_o  = !exception_o && !zero && (e >= 10'sd255);
      underflow_o = !exception_o && !zero && (e <= 10'sd0);
      if (exception_o)
         result_o = {sgn, 8'hFF, nan ? 23'h40_0000 : 23'd0};
      else if (zero || underflow_o)
         result_o = {sgn, 31'd0};
      else if (overflow_o)
         result_o = {sgn, 8'hFF, 23'd0};
      else
         result_o = {sgn, e[7:0], rnd[22:0]};
   end
endmodule

module Addition_Subtraction (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        add_bar_sub_i,
   output logic [31:0] result_o,
   output logic        exception_o
);
   logic [31:0]       x, y, bb;
   logic [7:0]        ex, ey, d;
   logic [26:0]       mx, my, mask;
   logic [27:0]       s;
   logic [23:0]       rnd;
   logic              sub, sgn, inc;
   logic signed [9:0] e;
   int                msb;

   // Align smaller operand with sticky, add/sub, normalise, round.
   always_comb begin
      bb = {b_i[31] ^ add_bar_sub_i, b_i[30:0]};
      if (a_i[30:0] >= bb[30:0]) begin
         x = a_i;
         y = bb;
      end else begin
         x = bb;
         y = a_i;
      end
      ex = x[30:23];
      ey = y[30:23];
      d = ex - ey;
      sub = x[31] ^ y[31];
      sgn = x[31];
      exception_o = (ex == 8'hFF) || (ey == 8'hFF);
      mx = {1'b1, x[22:0], 3'b000};
      my = (ey == 8'h00) ? 27'd0 : {1'b1, y[22:0], 3'b000};
      mask = '0;
      msb = 0;
      e = $signed({2'b00, ex});
      if (d >= 8'd27) begin
         my = {26'd0, |my};
      end else begin
         mask = ~(27'h7FF_FFFF << d);
         my = (my >> d) | {26'd0, |(my & mask)};
      end
      if (sub) s = {1'b0, mx} - {1'b0, my};
      else     s = {1'b0, mx} + {1'b0, my};
      if (s[27]) begin
         s = {1'b0, s[27:2], s[1] | s[0]};
         e = e + 10'sd1;
      end
      for (int i = 0; i < 27; i++)
         if (s[i]) msb = i;
      if (s != 28'd0) begin
         s = s << (26 - msb);
         e = e - 10'(26 - msb);
      end
      inc = s[2] & (s[1] | s[0] | s[3]);
      rnd = {1'b0, s[25:3]} + {23'd0, inc};
      e = e + $signed({9'd0, rnd[23]});
      if (exception_o) begin
         if (((ex == 8'hFF) && (x[22:0] != 23'd0)) ||
             ((ey == 8'hFF) && (y[22:0] != 23'd0)) ||
             ((ey == 8'hFF) && sub))
            result_o = 32'h7FC0_0000;
         else
            result_o = {sgn, 8'hFF, 23'd0};
      end else if (ex == 8'h00) begin
         result_o = {x[31] & y[31], 31'd0};
      end else if ((s == 28'd0) || (e <= 10'sd0)) begin
         result_o = 32'd0;
      end else if (e >= 10'sd255) begin
         result_o = {sgn, 8'hFF, 23'd0};
         exception_o = 1'b1;
      end else begin
         result_o = {sgn, e[7:0], rnd[22:0]};
      end
   end
endmodule

module fp_mac_lane
   import fp_matvec_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic        first_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [31:0] init_i,
   output logic [31:0] sum_o,
   output logic        exc_o
);
   logic [31:0] prod, addend, acc_q, acc_d;
   logic        m_exc, m_ovf, m_unf, a_exc;

   multiplier_fp u_mul (
      .a_i         (a_i),
      .b_i         (b_i),
      .result_o    (prod),
      .exception_o (m_exc),
      .overflow_o  (m_ovf),
      .underflow_o (m_unf)
   );

   assign addend = first_i ? init_i : acc_q;

   Addition_Subtraction u_add (
      .a_i           (addend),
      .b_i           (prod),
      .add_bar_sub_i (1'b0),
      .result_o      (acc_d),
      .exception_o   (a_exc)
   );

   assign sum_o = acc_d;
   assign exc_o = valid_i & (m_exc | m_ovf | m_unf | a_exc);

   // Running sum; gated lanes hold their value.
   always_ff @(posedge clk) begin
      if (rst)          acc_q <= FP_ZERO;
      else if (valid_i) acc_q <= acc_d;
   end
endmodule

// File: rtl/fp_matvec_seq.sv
// fp_matvec_seq: C = A*B (+D) computed by LANES MAC lanes,
// one column per clock, row groups processed in turn.
module fp_matvec_seq
   import fp_matvec_pkg::*;
#(
   parameter int BW    = 32,
   parameter int M     = 12,
   parameter int N     = 10,
   parameter int LANES = 4
) (
   input  logic           clk,
   input  logic           rst,
   fp_matvec_seq_if.slave bus
);
   localparam int G  = (M + LANES - 1) / LANES;
   localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);
   localparam int GW = (clog2(G) < 1) ? 1 : clog2(G);

   state_t            st_q;
   logic [CW-1:0]     col_q;
   logic [GW-1:0]     grp_q;
   logic [BW*M*N-1:0] a_q;
   logic [BW*N-1:0]   b_q;
   logic [BW*M-1:0]   d_q;
   logic [BW*M-1:0]   c_q;
   logic              bias_q, busy_q, done_q, exc_q;
   logic [BW-1:0]     lb;
   logic [BW-1:0]     la [LANES];
   logic [BW-1:0]     li [LANES];
   logic [BW-1:0]     ls [LANES];
   logic              lv [LANES];
   logic              le [LANES];
   int                lr [LANES];
   logic              first, last_col, last_grp, lane_exc;

   assign first    = (col_q == '0);
   assign last_col = (col_q == CW'(N - 1));
   assign last_grp = (grp_q == GW'(G - 1));

   // Map each lane to its row in the current group, fetch operands.
   always_comb begin
      lb = b_q[int'(col_q)*BW +: BW];
      for (int l = 0; l < LANES; l++) begin
         lr[l] = int'(grp_q) * LANES + l;
         lv[l] = (st_q == ST_MAC) && (lr[l] < M);
         if (lr[l] >= M) lr[l] = 0;
         la[l] = a_q[(lr[l]*N + int'(col_q))*BW +: BW];
         li[l] = bias_q ? d_q[lr[l]*BW +: BW] : FP_ZERO;
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      fp_mac_lane u_lane (
         .clk     (clk),
         .rst     (rst),
         .valid_i (lv[l]),
         .first_i (first),
         .a_i     (la[l]),
         .b_i     (lb),
         .init_i  (li[l]),
         .sum_o   (ls[l]),
         .exc_o   (le[l])
      );
   end

   // Merge exception flags of the active lanes.
   always_comb begin
      lane_exc = 1'b0;
      for (int l = 0; l < LANES; l++)
         lane_exc = lane_exc | le[l];
   end

   // Control FSM, counters, operand latches, result and flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= ST_IDLE;
         col_q  <= '0;
         grp_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         d_q    <= '0;
         c_q    <= '0;
         bias_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         exc_q  <= 1'b0;
      end else begin
         unique case (st_q)
            ST_IDLE: begin
               if (bus.start) begin
                  a_q    <= bus.A;
                  b_q    <= bus.B;
                  d_q    <= bus.D;
                  bias_q <= bus.use_bias;
                  exc_q  <= 1'b0;
                  col_q  <= '0;
                  grp_q  <= '0;
                  busy_q <= 1'b1;
                  st_q   <= ST_MAC;
               end
            end
            ST_MAC: begin
               if (lane_exc) exc_q <= 1'b1;
               if (last_col) begin
                  for (int l = 0; l < LANES; l++)
                     if (lv[l]) c_q[lr[l]*BW +: BW] <= ls[l];
                  col_q <= '0;
                  if (last_grp) begin
                     done_q <= 1'b1;
                     st_q   <= ST_DONE;
                  end else begin
                     grp_q <= grp_q + GW'(1);
                  end
               end else begin
                  col_q <= col_q + CW'(1);
               end
            end
            ST_DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               st_q   <= ST_IDLE;
            end
            default: st_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.C    = c_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.exc  = exc_q;
endmodule

// File: tb/tb_fp_matvec_seq.sv
// tb_fp_matvec_seq: directed tests of the sequential FP
// matrix-vector engine (LANES=4 and LANES=5 instances).
module tb_fp_matvec_seq;
   localparam int BW = 32;
   localparam int M  = 12;
   localparam int N  = 10;

   localparam logic [31:0] FI [10] = '{
      32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
      32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
      32'h4110_0000, 32'h4120_0000};
   localparam logic [31:0] FH [10] = '{
      32'h3FC0_0000, 32'h4020_0000, 32'h4060_0000, 32'h4090_0000,
      32'h40B0_0000, 32'h40D0_0000, 32'h40F0_0000, 32'h4108_0000,
      32'h4118_0000, 32'h4128_0000};
   localparam logic [31:0] F_ONE  = 32'h3F80_0000;
   localparam logic [31:0] F_TWO  = 32'h4000_0000;
   localparam logic [31:0] F_HALF = 32'h3F00_0000;
   localparam logic [31:0] F_20   = 32'h41A0_0000;
   localparam logic [31:0] F_INF  = 32'h7F80_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   fp_matvec_seq_if #(.BW(BW), .M(M), .N(N)) bus4 ();
   fp_matvec_seq_if #(.BW(BW), .M(M), .N(N)) bus5 ();

   fp_matvec_seq #(.BW(BW), .M(M), .N(N), .LANES(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   fp_matvec_seq #(.BW(BW), .M(M), .N(N), .LANES(5)) dut5 (
      .clk (clk),
      .rst (rst),
      .bus (bus5)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_identity(input logic [31:0] a00);
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++)
            bus4.A[(i*N+j)*BW +: BW] = (j == i % 10) ? F_ONE : 32'h0;
      bus4.A[0 +: BW] = a00;
      for (int j = 0; j < N; j++)
         bus4.B[j*BW +: BW] = FI[j];
   endtask

   // Start in the current cycle (cycle 0), optionally pulse start again
   // at cycles pa/pb, scramble B after cycle 0, sample through ncyc.
   task automatic run4(input int pa, input int pb, input int ncyc,
                       output int dcyc, output int dcnt, output int berr);
      logic [BW*N-1:0] bsave;
      bsave = bus4.B;
      dcyc = -1;
      dcnt = 0;
      berr = 0;
      bus4.start = 1'b1;
      tick();
      for (int c = 1; c <= ncyc; c++) begin
         bus4.start = (c == pa) || (c == pb);
         if (c == 2) bus4.B = '0;
         if (bus4.done === 1'b1) begin
            dcnt++;
            dcyc = c;
         end
         if (bus4.busy !== (c <= 31)) berr++;
         if (c < ncyc) tick();
      end
      bus4.start = 1'b0;
      bus4.B = bsave;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      rst = 1'b0;
      tick();
      n_chk++;
      if (bus4.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset busy: got %b expected 0", bus4.busy);
      end
      n_chk++;
      if (bus4.done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset done: got %b expected 0", bus4.done);
      end
      n_chk++;
      if (bus4.exc !== 1'b0) begin
         n_fail++;
         $display("FAIL reset exc: got %b expected 0", bus4.exc);
      end
      n_chk++;
      if (bus4.C !== '0) begin
         n_fail++;
         $display("FAIL reset C: got %h expected 0", bus4.C);
      end
      n_chk++;
      if (bus5.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset busy5: got %b expected 0", bus5.busy);
      end
   endtask

   task automatic test_identity();
      int dc, cnt, be;
      load_identity(F_ONE);
      bus4.use_bias = 1'b0;
      bus4.D = '0;
      run4(-1, -1, 33, dc, cnt, be);
      n_chk++;
      if (dc !== 31) begin
         n_fail++;
         $display("FAIL identity done_cycle: got %0d expected 31", dc);
      end
      n_chk++;
      if (cnt !== 1) begin
         n_fail++;
         $display("FAIL identity done_count: got %0d expected 1", cnt);
      end
      n_chk++;
      if (be !== 0) begin
         n_fail++;
         $display("FAIL identity busy_window: got %0d bad cycles expected 0", be);
      end
      for (int i = 0; i < M; i++) begin
         n_chk++;
         if (bus4.C[i*BW +: BW] !== FI[i%10]) begin
            n_fail++;
            $display("FAIL identity C[%0d]: got %h expected %h",
                     i, bus4.C[i*BW +: BW], FI[i%10]);
         end
      end
      n_chk++;
      if (bus4.exc !== 1'b0) begin
         n_fail++;
         $display("FAIL identity exc: got %b expected 0", bus4.exc);
      end
   endtask

   task automatic test_bias();
      int dc, cnt, be;
      load_identity(F_ONE);
      bus4.use_bias = 1'b1;
      bus4.D = {M{F_HALF}};
      run4(-1, -1, 33, dc, cnt, be);
      bus4.use_bias = 1'b0;
      n_chk++;
      if (dc !== 31) begin
         n_fail++;
         $display("FAIL bias done_cycle: got %0d expected 31", dc);
      end
      for (int i = 0; i < M; i++) begin
         n_chk++;
         if (bus4.C[i*BW +: BW] !== FH[i%10]) begin
            n_fail++;
            $display("FAIL bias C[%0d]: got %h expected %h",
                     i, bus4.C[i*BW +: BW], FH[i%10]);
         end
      end
   endtask

   task automatic test_lanes5();
      int dc, cnt;
      dc = -1;
      cnt = 0;
      bus5.A = {(M*N){F_ONE}};
      bus5.B = {N{F_TWO}};
      bus5.D = {M{F_HALF}};
      bus5.use_bias = 1'b0;
      bus5.start = 1'b1;
      tick();
      bus5.start = 1'b0;
      for (int c = 1; c <= 33; c++) begin
         if (bus5.done === 1'b1) begin
            cnt++;
            dc = c;
         end
         if (c < 33) tick();
      end
      n_chk++;
      if (dc !== 31) begin
         n_fail++;
         $display("FAIL lanes5 done_cycle: got %0d expected 31", dc);
      end
      n_chk++;
      if (cnt !== 1) begin
         n_fail++;
         $display("FAIL lanes5 done_count: got %0d expected 1", cnt);
      end
      for (int i = 0; i < M; i++) begin
         n_chk++;
         if (bus5.C[i*BW +: BW] !== F_20) begin
            n_fail++;
            $display("FAIL lanes5 C[%0d]: got %h expected %h",
                     i, bus5.C[i*BW +: BW], F_20);
         end
      end
      n_chk++;
      if (bus5.exc !== 1'b0) begin
         n_fail++;
         $display("FAIL lanes5 exc: got %b expected 0", bus5.exc);
      end
   endtask

   task automatic test_start_ignored();
      int dc, cnt, be;
      load_identity(F_ONE);
      run4(5, 31, 32, dc, cnt, be);
      n_chk++;
      if (cnt !== 1) begin
         n_fail++;
         $display("FAIL ignore done_count: got %0d expected 1", cnt);
      end
      n_chk++;
      if (dc !== 31) begin
         n_fail++;
         $display("FAIL ignore done_cycle: got %0d expected 31", dc);
      end
      n_chk++;
      if (be !== 0) begin
         n_fail++;
         $display("FAIL ignore busy_window: got %0d bad cycles expected 0", be);
      end
      run4(-1, -1, 33, dc, cnt, be);
      n_chk++;
      if (dc !== 31 || cnt !== 1) begin
         n_fail++;
         $display("FAIL ignore restart: got cycle %0d count %0d expected 31 1", dc, cnt);
      end
      n_chk++;
      if (bus4.C[3*BW +: BW] !== FI[3]) begin
         n_fail++;
         $display("FAIL ignore C[3]: got %h expected %h", bus4.C[3*BW +: BW], FI[3]);
      end
   endtask

   task automatic test_exc();
      int dc, cnt, be;
      load_identity(F_INF);
      run4(-1, -1, 32, dc, cnt, be);
      n_chk++;
      if (bus4.exc !== 1'b1) begin
         n_fail++;
         $display("FAIL exc sticky: got %b expected 1", bus4.exc);
      end
      n_chk++;
      if (bus4.C[0 +: BW] !== F_INF) begin
         n_fail++;
         $display("FAIL exc C[0]: got %h expected %h", bus4.C[0 +: BW], F_INF);
      end
      n_chk++;
      if (bus4.C[BW +: BW] !== FI[1]) begin
         n_fail++;
         $display("FAIL exc C[1]: got %h expected %h", bus4.C[BW +: BW], FI[1]);
      end
      load_identity(F_ONE);
      bus4.start = 1'b1;
      tick();
      bus4.start = 1'b0;
      n_chk++;
      if (bus4.exc !== 1'b0 || bus4.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL exc clear: got exc %b busy %b expected 0 1", bus4.exc, bus4.busy);
      end
      repeat (32) tick();
      n_chk++;
      if (bus4.exc !== 1'b0 || bus4.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL exc clean_end: got exc %b busy %b expected 0 0", bus4.exc, bus4.busy);
      end
      n_chk++;
      if (bus4.C[0 +: BW] !== F_ONE) begin
         n_fail++;
         $display("FAIL exc clean C[0]: got %h expected %h", bus4.C[0 +: BW], F_ONE);
      end
   endtask

   task automatic test_rst_mid();
      int dc, cnt, be;
      load_identity(F_INF);
      bus4.start = 1'b1;
      tick();
      bus4.start = 1'b0;
      repeat (9) tick();
      n_chk++;
      if (bus4.exc !== 1'b1 || bus4.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid pre: got exc %b busy %b expected 1 1", bus4.exc, bus4.busy);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_chk++;
      if (bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid busy_done: got %b %b expected 0 0", bus4.busy, bus4.done);
      end
      n_chk++;
      if (bus4.exc !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid exc: got %b expected 0", bus4.exc);
      end
      n_chk++;
      if (bus4.C !== '0) begin
         n_fail++;
         $display("FAIL rstmid C: got %h expected 0", bus4.C);
      end
      load_identity(F_ONE);
      run4(-1, -1, 33, dc, cnt, be);
      n_chk++;
      if (dc !== 31) begin
         n_fail++;
         $display("FAIL rstmid done_cycle: got %0d expected 31", dc);
      end
      for (int i = 0; i < M; i++) begin
         n_chk++;
         if (bus4.C[i*BW +: BW] !== FI[i%10]) begin
            n_fail++;
            $display("FAIL rstmid C[%0d]: got %h expected %h",
                     i, bus4.C[i*BW +: BW], FI[i%10]);
         end
      end
   endtask

   initial begin
      bus4.start = 1'b0;
      bus4.use_bias = 1'b0;
      bus4.A = '0;
      bus4.B = '0;
      bus4.D = '0;
      bus5.start = 1'b0;
      bus5.use_bias = 1'b0;
      bus5.A = '0;
      bus5.B = '0;
      bus5.D = '0;
      test_reset();
      test_identity();
      test_bias();
      test_lanes5();
      test_start_ignored();
      test_exc();
      test_rst_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
